// File: rtl/rect_loop_pkg.sv
// Shared types and constants for the rectangle-flip loop controller.
package rect_loop_pkg;

  // Coordinate width, fixed by the flip stage's 2-bit corner inputs.
  localparam int unsigned IDX_W = 2;

  // Default geometry; the controller itself is parameterised.
  localparam int unsigned ROWS_DEF = 4;
  localparam int unsigned COLS_DEF = 4;
  localparam int unsigned N_DEF    = ROWS_DEF * COLS_DEF;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  // Matrix word at the default geometry; bit index = c*ROWS + r.
  typedef logic [N_DEF-1:0] mat_t;

  // Number of rectangles (r1<r2, c1<c2) visited in one pass.
  function automatic int unsigned rects_per_pass(input int unsigned rows,
                                                 input int unsigned cols);
    return ((rows * (rows - 1)) / 2) * ((cols * (cols - 1)) / 2);
  endfunction

  localparam int unsigned RECTS_PER_PASS = rects_per_pass(ROWS_DEF, COLS_DEF);

endpackage

// File: rtl/rect_loop_ctrl_if.sv
// Bus between the loop controller (master) and the external flip stage (slave).
interface rect_loop_ctrl_if
  import rect_loop_pkg::*;
#(
  parameter int unsigned N = 16
);
  logic [N-1:0]     flip_m;
  logic [IDX_W-1:0] flip_r1;
  logic [IDX_W-1:0] flip_r2;
  logic [IDX_W-1:0] flip_c1;
  logic [IDX_W-1:0] flip_c2;
  // Combinational, same-cycle answer from the flip stage.
  logic [N-1:0]     flip_result;

  modport master (
    output flip_m, flip_r1, flip_r2, flip_c1, flip_c2,
    input  flip_result
  );

  modport slave (
    input  flip_m, flip_r1, flip_r2, flip_c1, flip_c2,
    output flip_result
  );
endinterface

// File: rtl/rect_popcount.sv
// Combinational population count of an N-bit vector.
module rect_popcount #(
  parameter  int unsigned N = 16,
  localparam int unsigned W = $clog2(N + 1)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] count_o
);

  // Ripple-add each bit; N is at most 16 so a simple chain is fine.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/rect_loop_ctrl.sv
// Enumerates every rectangle of a binary matrix, keeping flips that lower the
// Hamming weight, and repeats passes until no gain or the pass limit.
module rect_loop_ctrl
  import rect_loop_pkg::*;
#(
  parameter  int unsigned ROWS       = 4,
  parameter  int unsigned COLS       = 4,
  parameter  int unsigned MAX_PASSES = 8,
  localparam int unsigned N          = ROWS * COLS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N-1:0]          m_in,
  output logic                  busy,
  output logic                  done,
  output logic [N-1:0]          m_out,
  output logic [7:0]            flip_count,
  output logic [3:0]            pass_count,
  output logic                  converged,
  rect_loop_ctrl_if.master      fs
);

  localparam int unsigned W = $clog2(N + 1);

  localparam logic [IDX_W-1:0] RMax  = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] RLast = IDX_W'(ROWS - 2);
  localparam logic [IDX_W-1:0] CMax  = IDX_W'(COLS - 1);
  localparam logic [IDX_W-1:0] CLast = IDX_W'(COLS - 2);

  state_e           state_q;
  logic [N-1:0]     cur_q;
  logic [IDX_W-1:0] r1_q, r2_q, c1_q, c2_q;
  logic [7:0]       flip_cnt_q;
  logic [3:0]       pass_cnt_q;
  logic             conv_q, improved_q, busy_q, done_q;

  logic [W-1:0]     w_cur, w_flip;
  logic             accept, last_rect;
  logic [4:0]       pass_next;

  rect_popcount #(.N(N)) u_pop_cur (
    .vec_i   (cur_q),
    .count_o (w_cur)
  );

  rect_popcount #(.N(N)) u_pop_flip (
    .vec_i   (fs.flip_result),
    .count_o (w_flip)
  );

  // Accept test and end-of-pass detection for the rectangle on the bus.
  always_comb begin
    accept    = (state_q == StScan) && (w_flip < w_cur);
    last_rect = (r1_q == RLast) && (r2_q == RMax) && (c1_q == CLast) && (c2_q == CMax);
    pass_next = {1'b0, pass_cnt_q} + 5'd1;
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      r1_q       <= IDX_W'(0);
      r2_q       <= IDX_W'(1);
      c1_q       <= IDX_W'(0);
      c2_q       <= IDX_W'(1);
      flip_cnt_q <= '0;
      pass_cnt_q <= '0;
      conv_q     <= 1'b0;
      improved_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_q      <= m_in;
            r1_q       <= IDX_W'(0);
            r2_q       <= IDX_W'(1);
            c1_q       <= IDX_W'(0);
            c2_q       <= IDX_W'(1);
            flip_cnt_q <= '0;
            pass_cnt_q <= '0;
            improved_q <= 1'b0;
            conv_q     <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StScan;
          end
        end
        StScan: begin
          if (accept) begin
            cur_q      <= fs.flip_result;
            improved_q <= 1'b1;
            if (flip_cnt_q != 8'hFF) flip_cnt_q <= flip_cnt_q + 8'd1;
          end
          if (last_rect) begin
            pass_cnt_q <= pass_cnt_q + 4'd1;
            r1_q       <= IDX_W'(0);
            r2_q       <= IDX_W'(1);
            c1_q       <= IDX_W'(0);
            c2_q       <= IDX_W'(1);
            if (!(improved_q || accept)) begin
              conv_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (pass_next == 5'(MAX_PASSES)) begin
              conv_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              // Overrides the set above: a fresh pass starts with no gain.
              improved_q <= 1'b0;
            end
          end else if (c2_q != CMax) begin
            c2_q <= c2_q + IDX_W'(1);
          end else if (c1_q != CLast) begin
            c1_q <= c1_q + IDX_W'(1);
            c2_q <= c1_q + IDX_W'(2);
          end else begin
            c1_q <= IDX_W'(0);
            c2_q <= IDX_W'(1);
            if (r2_q != RMax) begin
              r2_q <= r2_q + IDX_W'(1);
            end else begin
              r1_q <= r1_q + IDX_W'(1);
              r2_q <= r1_q + IDX_W'(2);
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign m_out      = cur_q;
  assign flip_count = flip_cnt_q;
  assign pass_count = pass_cnt_q;
  assign converged  = conv_q;

  assign fs.flip_m  = cur_q;
  assign fs.flip_r1 = r1_q;
  assign fs.flip_r2 = r2_q;
  assign fs.flip_c1 = c1_q;
  assign fs.flip_c2 = c2_q;

endmodule

// File: tb/tb_rect_loop_ctrl.sv
// Scoreboard bench for rect_loop_ctrl with a behavioural flip stage.
module tb_rect_loop_ctrl;
  import rect_loop_pkg::*;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned N    = ROWS * COLS;
  localparam int          RPP  = 36;

  typedef struct {
    string      name;
    logic [15:0] m;
    logic [7:0] fc;
    logic [3:0] pc;
    logic       conv;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // DUT A: default pass limit; DUT B: single pass.
  logic       start_a = 1'b0, start_b = 1'b0;
  mat_t       m_in_a = '0, m_in_b = '0;
  logic       busy_a, done_a, conv_a, busy_b, done_b, conv_b;
  mat_t       m_out_a, m_out_b;
  logic [7:0] fc_a, fc_b;
  logic [3:0] pc_a, pc_b;

  rect_loop_ctrl_if #(.N(N)) fa ();
  rect_loop_ctrl_if #(.N(N)) fb ();

  // External flip stage: invert the four corner bits.
  function automatic logic [N-1:0] flip_model(input logic [N-1:0] m,
      input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] c1, input logic [1:0] c2);
    logic [N-1:0] r;
    r = m;
    r[int'(c1) * ROWS + int'(r1)] = ~r[int'(c1) * ROWS + int'(r1)];
    r[int'(c1) * ROWS + int'(r2)] = ~r[int'(c1) * ROWS + int'(r2)];
    r[int'(c2) * ROWS + int'(r1)] = ~r[int'(c2) * ROWS + int'(r1)];
    r[int'(c2) * ROWS + int'(r2)] = ~r[int'(c2) * ROWS + int'(r2)];
    return r;
  endfunction

  assign fa.flip_result = flip_model(fa.flip_m, fa.flip_r1, fa.flip_r2, fa.flip_c1, fa.flip_c2);
  assign fb.flip_result = flip_model(fb.flip_m, fb.flip_r1, fb.flip_r2, fb.flip_c1, fb.flip_c2);

  rect_loop_ctrl #(.ROWS(ROWS), .COLS(COLS), .MAX_PASSES(8)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .m_in       (m_in_a),
    .busy       (busy_a),
    .done       (done_a),
    .m_out      (m_out_a),
    .flip_count (fc_a),
    .pass_count (pc_a),
    .converged  (conv_a),
    .fs         (fa)
  );

  rect_loop_ctrl #(.ROWS(ROWS), .COLS(COLS), .MAX_PASSES(1)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .m_in       (m_in_b),
    .busy       (busy_b),
    .done       (done_b),
    .m_out      (m_out_b),
    .flip_count (fc_b),
    .pass_count (pc_b),
    .converged  (conv_b),
    .fs         (fb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_result(input exp_t e, input mat_t m, input logic [7:0] fc,
                            input logic [3:0] pc, input logic conv);
    chk({e.name, " m_out"}, 32'(m), 32'(e.m));
    chk({e.name, " flip_count"}, 32'(fc), 32'(e.fc));
    chk({e.name, " pass_count"}, 32'(pc), 32'(e.pc));
    chk({e.name, " converged"}, 32'(conv), 32'(e.conv));
    chk({e.name, " done cycle"}, 32'(cyc), 32'(e.done_cyc));
  endtask

  // Monitor A: pop and compare on every done pulse; done must last one cycle.
  logic done_a_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done_a_prev) begin
      chk("A done width", 32'(done_a), 32'd0);
      chk("A busy after done", 32'(busy_a), 32'd0);
    end
    if (done_a) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL A unexpected done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        e = q_a.pop_front();
        chk_result(e, m_out_a, fc_a, pc_a, conv_a);
      end
    end
    done_a_prev <= done_a;
  end

  // Monitor B.
  always @(negedge clk) begin
    exp_t e;
    if (done_b) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL B unexpected done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        e = q_b.pop_front();
        chk_result(e, m_out_b, fc_b, pc_b, conv_b);
        chk("B busy during done", 32'(busy_b), 32'd1);
      end
    end
  end

  // Issue a start on A; when push is set, the expected result is queued.
  task automatic go_a(input string name, input mat_t m, input logic push, input logic [15:0] em,
                      input logic [7:0] efc, input logic [3:0] epc, input logic econv,
                      input int passes);
    exp_t e;
    @(negedge clk);
    m_in_a  = m;
    start_a = 1'b1;
    if (push) begin
      e.name = name; e.m = em; e.fc = efc; e.pc = epc; e.conv = econv;
      e.done_cyc = cyc + 1 + RPP * passes;
      q_a.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic go_b(input string name, input mat_t m, input logic [15:0] em,
                      input logic [7:0] efc, input logic [3:0] epc, input logic econv,
                      input int passes);
    exp_t e;
    @(negedge clk);
    m_in_b  = m;
    start_b = 1'b1;
    e.name = name; e.m = em; e.fc = efc; e.pc = epc; e.conv = econv;
    e.done_cyc = cyc + 1 + RPP * passes;
    q_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain timeout: got %0d/%0d pending, expected 0", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset m_out", 32'(m_out_a), 32'h0);
    chk("reset flip_count", 32'(fc_a), 32'h0);
    chk("reset pass_count", 32'(pc_a), 32'h0);
    chk("reset converged", 32'(conv_a), 32'h0);
    chk("reset busy/done", {30'd0, busy_a, done_a}, 32'h0);
    chk("reset coords", {24'd0, fa.flip_r1, fa.flip_r2, fa.flip_c1, fa.flip_c2}, 32'h11);
    rst_n = 1'b1;

    go_a("zero", 16'h0000, 1'b1, 16'h0000, 8'd0, 4'd1, 1'b1, 1);
    chk("busy in scan", 32'(busy_a), 32'd1);
    drain(200);
    go_a("four corners", 16'h0033, 1'b1, 16'h0000, 8'd1, 4'd2, 1'b1, 2);
    drain(200);
    go_a("three corners", 16'h0013, 1'b1, 16'h0020, 8'd1, 4'd2, 1'b1, 2);
    drain(200);
    go_a("two corners", 16'h0011, 1'b1, 16'h0011, 8'd0, 4'd1, 1'b1, 1);
    drain(200);
    chk("idle coords", {24'd0, fa.flip_r1, fa.flip_r2, fa.flip_c1, fa.flip_c2}, 32'h11);

    go_b("pass limit", 16'h0033, 16'h0000, 8'd1, 4'd1, 1'b0, 1);
    drain(200);

    // Start pulsed in SCAN cycle 5 must not restart or queue a run.
    go_a("start ignored", 16'h0033, 1'b1, 16'h0000, 8'd1, 4'd2, 1'b1, 2);
    repeat (3) @(negedge clk);
    m_in_a  = 16'hFFFF;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    drain(200);
    repeat (5) @(negedge clk);
    chk("no queued run busy", 32'(busy_a), 32'd0);
    chk("hold m_out", 32'(m_out_a), 32'h0);
    chk("hold pass_count", 32'(pc_a), 32'd2);

    // Reset at SCAN cycle 10: immediate reset values, no done pulse.
    go_a("aborted", 16'h0013, 1'b0, 16'h0, 8'd0, 4'd0, 1'b0, 1);
    repeat (8) @(negedge clk);
    chk("pre-abort flip_count", 32'(fc_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort m_out", 32'(m_out_a), 32'h0);
    chk("abort flip_count", 32'(fc_a), 32'h0);
    chk("abort busy/done", {30'd0, busy_a, done_a}, 32'h0);
    chk("abort coords", {24'd0, fa.flip_r1, fa.flip_r2, fa.flip_c1, fa.flip_c2}, 32'h11);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    go_a("after abort", 16'h0033, 1'b1, 16'h0000, 8'd1, 4'd2, 1'b1, 2);
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
